// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam bcd_digit_t DD_THRESH     = 4'd8;
    localparam bcd_digit_t DD_ADJ        = 4'd3;

    function automatic logic digit_invalid(input bcd_digit_t d);
        return d > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse double-dabble correction: a nibble that reads 8 or more after
// the right shift had a 1 shifted in from the digit above, so take 3 off it.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adjusted
);

    assign adjusted = (digit >= DD_THRESH) ? bcd_digit_t'(digit - DD_ADJ) : digit;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential signed BCD-to-two's-complement converter (reverse double-dabble,
// one shift per clock). Build option SATURATE_EN clamps overflowed results.
//
// state | meaning
// IDLE  | waiting for valid; loads work register, sign and digit-error flag
// SHIFT | one shift+adjust per cycle while cnt < 4*DIGITS, then one settle cycle
// DONE  | result is final; output registers load on the next edge
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [4*DIGITS-1:0]   BCD_code,
    input  logic                  sign,
    output logic                  busy,
    output logic                  bin_ready,
    output logic [BIN_W-1:0]      bin_result,
    output logic                  overflow,
    output logic                  bcd_error
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = 2 * BCD_W;
    localparam int CNT_W  = $clog2(BCD_W + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(BCD_W);
    localparam logic [31:0]      POS_LIM = 32'((2 ** (BIN_W - 1)) - 1);
    localparam logic [31:0]      NEG_LIM = POS_LIM + 32'd1;

    state_t              state, next_state;
    logic [WORK_W-1:0]   work;
    logic [WORK_W-1:0]   shifted;
    logic [BCD_W-1:0]    adjusted;
    logic [CNT_W-1:0]    cnt;
    logic                sign_q;
    logic                err_q;
    logic                any_bad;
    logic [31:0]         mag_ext;
    logic [BIN_W-1:0]    mag_bin;
    logic [BIN_W-1:0]    res_d;
    logic                ovf_d;
    logic                busy_q;

    assign shifted = work >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (shifted[BCD_W + 4*g +: 4]),
            .adjusted (adjusted[4*g +: 4])
        );
    end

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_invalid(BCD_code[4*i +: 4])) any_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (valid) next_state = SHIFT;
            SHIFT:   if (cnt == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            work   <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        work   <= {BCD_code, BCD_W'(0)};
                        sign_q <= sign;
                        err_q  <= any_bad;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                    end else begin
                        work <= {adjusted, shifted[BCD_W-1:0]};
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mag_ext = 32'(work[BCD_W-1:0]);
    assign mag_bin = mag_ext[BIN_W-1:0];

    // Negative range reaches one further than positive, so -2**(BIN_W-1) is legal.
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        if (!err_q) begin
            if (sign_q ? (mag_ext > NEG_LIM) : (mag_ext > POS_LIM)) begin
                ovf_d = 1'b1;
`ifdef SATURATE_EN
                res_d = sign_q ? {1'b1, {(BIN_W-1){1'b0}}} : {1'b0, {(BIN_W-1){1'b1}}};
`else
                res_d = '0;
`endif
            end else begin
                res_d = sign_q ? BIN_W'(-mag_bin) : mag_bin;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q     <= 1'b0;
            bin_ready  <= 1'b0;
            bin_result <= '0;
            overflow   <= 1'b0;
            bcd_error  <= 1'b0;
        end else begin
            busy_q    <= (state != IDLE);
            bin_ready <= (state == DONE);
            if (state == DONE) begin
                bin_result <= res_d;
                overflow   <= ovf_d;
                bcd_error  <= err_q;
            end
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboarded bench for bcd_to_binary: randomized and directed requests,
// decimal reference model, monitor checks results, latency and busy window.
module tb_bcd_to_binary;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 8;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int LAT    = 4 * DIGITS + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              valid = 1'b0;
    logic              sign = 1'b0;
    logic [BCD_W-1:0]  BCD_code = '0;
    logic              busy;
    logic              bin_ready;
    logic [BIN_W-1:0]  bin_result;
    logic              overflow;
    logic              bcd_error;

    typedef struct {
        logic [BIN_W-1:0] res;
        logic             ovf;
        logic             err;
        int               due;
        logic [BCD_W-1:0] bcd;
        logic             s;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   la         = -100;

    bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid),
        .BCD_code   (BCD_code),
        .sign       (sign),
        .busy       (busy),
        .bin_ready  (bin_ready),
        .bin_result (bin_result),
        .overflow   (overflow),
        .bcd_error  (bcd_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Reference: decimal value from the digits, then the signed-range rules.
    function automatic exp_t model(input logic [BCD_W-1:0] bcd, input logic s, input int due);
        exp_t e;
        int   mag = 0;
        bit   err = 0;
        logic [3:0] d;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = bcd[4*i +: 4];
            if (d > 4'd9) err = 1;
            mag = mag * 10 + int'(d);
        end
        e.due = due; e.bcd = bcd; e.s = s;
        e.err = err; e.ovf = 1'b0; e.res = '0;
        if (!err) begin
            if (s ? (mag > 2 ** (BIN_W - 1)) : (mag > 2 ** (BIN_W - 1) - 1)) begin
                e.ovf = 1'b1;
`ifdef SATURATE_EN
                e.res = s ? BIN_W'(-(2 ** (BIN_W - 1))) : BIN_W'(2 ** (BIN_W - 1) - 1);
`else
                e.res = '0;
`endif
            end else begin
                e.res = s ? BIN_W'(-mag) : BIN_W'(mag);
            end
        end
        return e;
    endfunction

    function automatic logic [BCD_W-1:0] rand_bcd();
        logic [BCD_W-1:0] b;
        for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(0, 9) == 0) b[4*i +: 4] = 4'($urandom_range(10, 15));
            else                           b[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return b;
    endfunction

    // A request sampled at edge e is taken only if the converter is back in IDLE.
    task automatic drive_cycle(input bit v, input logic [BCD_W-1:0] b, input logic s);
        int e;
        @(negedge clk);
        valid = v; BCD_code = b; sign = s;
        e = cyc + 1;
        if (v && reset && e >= la + LAT + 1) begin
            sb.push_back(model(b, s, e + LAT));
            la = e;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, rand_bcd(), 1'($urandom));
    endtask

    task automatic send(input logic [BCD_W-1:0] b, input logic s);
        drive_cycle(1, b, s);
        idle(LAT + 2);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_result"}, int'(bin_result), 0);
        check({tag, "_ovf"},    int'(overflow),   0);
        check({tag, "_err"},    int'(bcd_error),  0);
        check({tag, "_ready"},  int'(bin_ready),  0);
        check({tag, "_busy"},   int'(busy),       0);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk); #1;
            check("busy", int'(busy), int'(cyc >= la + 1 && cyc <= la + LAT));
            if (bin_ready) begin
                if (sb.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_ready at cycle %0d: got bin_ready=1, expected 0", cyc);
                end else begin
                    x = sb.pop_front();
                    check("latency",    cyc,              x.due);
                    check("bin_result", int'(bin_result), int'(x.res));
                    check("overflow",   int'(overflow),   int'(x.ovf));
                    check("bcd_error",  int'(bcd_error),  int'(x.err));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                x = sb.pop_front();
                compared++; mismatched++;
                $display("FAIL missing_ready at cycle %0d: got no bin_ready, expected at %0d for %0h", cyc, x.due, x.bcd);
            end
        end
    end

    initial begin
        #2_000_000;
        mismatched++;
        $display("FAIL watchdog: got no finish, expected end before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        idle(3);
        check_zero("reset");
        @(negedge clk) reset = 1'b1;
        idle(2);

        send(12'h127, 1'b0);
        send(12'h128, 1'b1);
        send(12'h128, 1'b0);
        send(12'h1A5, 1'b0);
        send(12'h000, 1'b1);

        // Second request lands while busy and must be dropped.
        drive_cycle(1, 12'h045, 1'b1);
        idle(4);
        drive_cycle(1, 12'h099, 1'b0);
        idle(LAT + 2);

        // Abort mid-conversion.
        drive_cycle(1, 12'h321, 1'b0);
        idle(6);
        @(negedge clk);
        reset = 1'b0;
        valid = 1'b0;
        sb.delete();
        la = -100;
        #1;
        check_zero("abort");
        idle(4);
        check_zero("abort_hold");
        @(negedge clk) reset = 1'b1;
        send(12'h999, 1'b0);

        // valid held high: accepted once per conversion, back to back.
        for (int i = 0; i < 3 * (LAT + 1) + 2; i++) drive_cycle(1, rand_bcd(), 1'($urandom));
        idle(LAT + 2);

        for (int i = 0; i < 60; i++) begin
            drive_cycle(1, rand_bcd(), 1'($urandom));
            idle($urandom_range(0, 20));
        end
        idle(LAT + 4);

        check("drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
